// File: rtl/temp_buffer_sequencer.sv
// Single-port BRAM sequencer for the temperature history ring buffer:
// sample write + statistics scan + restoring divide, and host readback.
module temp_buffer_sequencer #(
    parameter int DEPTH = 10,
    parameter int AW    = 4,
    parameter int DW    = 8,
    parameter int SW    = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] sample_in,
    input  logic          sample_valid,
    output logic          sample_ready,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_ack,
    output logic [DW-1:0] rd_data,
    output logic          bram_we,
    output logic [AW-1:0] bram_addr,
    output logic [DW-1:0] bram_din,
    input  logic [DW-1:0] bram_dout,
    output logic [DW-1:0] avg_temp,
    output logic [DW-1:0] max_temp,
    output logic [DW-1:0] min_temp,
    output logic          stats_valid,
    output logic [AW-1:0] entry_count
);

    localparam int CW = $clog2(SW);

    typedef enum logic [2:0] {
        IDLE, WRITE, SCAN, DRAIN, DIV, DONE, RD_ADDR, RD_DATA
    } state_t;

    state_t        state;
    logic [AW-1:0] wp;
    logic [SW-1:0] sum;
    logic [SW-1:0] quo;
    logic [SW-1:0] rem;
    logic [DW-1:0] mx;
    logic [DW-1:0] mn;
    logic [DW-1:0] rd_hold;
    logic [CW-1:0] div_cnt;

    logic [SW:0]   r_shift;
    logic [SW-1:0] r_diff;
    logic [SW-1:0] rem_next;
    logic [SW-1:0] q_next;
    logic          ge;

    // One restoring-division step; the divisor is the live entry count.
    always_comb begin
        r_shift  = {rem, quo[SW-1]};
        ge       = r_shift >= (SW+1)'(entry_count);
        r_diff   = r_shift[SW-1:0] - SW'(entry_count);
        rem_next = ge ? r_diff : r_shift[SW-1:0];
        q_next   = {quo[SW-2:0], ge};
    end

    // The BRAM has no output register, so read data is only valid during RD_DATA.
    assign rd_data = rd_ack ? bram_dout : rd_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wp           <= '0;
            entry_count  <= '0;
            sum          <= '0;
            quo          <= '0;
            rem          <= '0;
            mx           <= '0;
            mn           <= '1;
            div_cnt      <= '0;
            rd_hold      <= '0;
            avg_temp     <= '0;
            max_temp     <= '0;
            min_temp     <= '1;
            stats_valid  <= 1'b0;
            rd_ack       <= 1'b0;
            bram_we      <= 1'b0;
            bram_addr    <= '0;
            bram_din     <= '0;
            sample_ready <= 1'b1;
        end else begin
            bram_we     <= 1'b0;
            rd_ack      <= 1'b0;
            stats_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (sample_valid) begin
                        bram_we      <= 1'b1;
                        bram_addr    <= wp;
                        bram_din     <= sample_in;
                        sample_ready <= 1'b0;
                        state        <= WRITE;
                    end else if (rd_req) begin
                        bram_addr    <= rd_addr;
                        sample_ready <= 1'b0;
                        state        <= RD_ADDR;
                    end
                end
                WRITE: begin
                    wp <= (wp == AW'(DEPTH - 1)) ? '0 : wp + 1'b1;
                    if (entry_count != AW'(DEPTH))
                        entry_count <= entry_count + 1'b1;
                    sum       <= '0;
                    mx        <= '0;
                    mn        <= '1;
                    bram_addr <= '0;
                    state     <= SCAN;
                end
                SCAN: begin
                    // Data for the previous address arrives this cycle.
                    if (bram_addr != '0) begin
                        sum <= sum + SW'(bram_dout);
                        if (bram_dout > mx) mx <= bram_dout;
                        if (bram_dout < mn) mn <= bram_dout;
                    end
                    if (bram_addr == entry_count - 1'b1)
                        state <= DRAIN;
                    else
                        bram_addr <= bram_addr + 1'b1;
                end
                DRAIN: begin
                    if (bram_dout > mx) mx <= bram_dout;
                    if (bram_dout < mn) mn <= bram_dout;
                    quo     <= sum + SW'(bram_dout);
                    rem     <= '0;
                    div_cnt <= '0;
                    state   <= DIV;
                end
                DIV: begin
                    rem     <= rem_next;
                    quo     <= q_next;
                    div_cnt <= div_cnt + 1'b1;
                    if (div_cnt == CW'(SW - 1)) begin
                        avg_temp    <= q_next[DW-1:0];
                        max_temp    <= mx;
                        min_temp    <= mn;
                        stats_valid <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    sample_ready <= 1'b1;
                    state        <= IDLE;
                end
                RD_ADDR: begin
                    rd_ack <= 1'b1;
                    state  <= RD_DATA;
                end
                RD_DATA: begin
                    rd_hold      <= bram_dout;
                    sample_ready <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_temp_buffer_sequencer.sv
// Directed and random checks of temp_buffer_sequencer against a
// ring-buffer reference model, with a behavioural single-port BRAM.
module tb_temp_buffer_sequencer;

    localparam int DEPTH = 10;
    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int SW    = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] sample_in = '0;
    logic          sample_valid = 1'b0;
    logic          sample_ready;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_ack;
    logic [DW-1:0] rd_data;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din;
    logic [DW-1:0] bram_dout;
    logic [DW-1:0] avg_temp;
    logic [DW-1:0] max_temp;
    logic [DW-1:0] min_temp;
    logic          stats_valid;
    logic [AW-1:0] entry_count;

    temp_buffer_sequencer #(
        .DEPTH(DEPTH), .AW(AW), .DW(DW), .SW(SW)
    ) dut (
        .clk(clk), .rst(rst),
        .sample_in(sample_in), .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
        .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
        .bram_dout(bram_dout),
        .avg_temp(avg_temp), .max_temp(max_temp), .min_temp(min_temp),
        .stats_valid(stats_valid), .entry_count(entry_count)
    );

    always #5 clk = ~clk;

    // Single-port BRAM, synchronous read, no output register
    logic [DW-1:0] mem [16];
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        bram_dout = '0;
    end
    always @(posedge clk) begin
        if (bram_we) mem[bram_addr] <= bram_din;
        bram_dout <= mem[bram_addr];
    end

    int errors = 0;
    int checks = 0;

    // Reference model: logical ring buffer contents
    int mem_m [DEPTH];
    int wp_m  = 0;
    int cnt_m = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic ref_stats(output int a, output int mx, output int mn);
        int s;
        s = 0; mx = 0; mn = 255;
        for (int i = 0; i < cnt_m; i++) begin
            s += mem_m[i];
            if (mem_m[i] > mx) mx = mem_m[i];
            if (mem_m[i] < mn) mn = mem_m[i];
        end
        a = (cnt_m == 0) ? 0 : s / cnt_m;
    endtask

    task automatic model_write(input int v);
        mem_m[wp_m] = v;
        wp_m = (wp_m + 1) % DEPTH;
        if (cnt_m < DEPTH) cnt_m++;
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!sample_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("ready_wait", k < 100, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        sample_valid = 1'b0;
        rd_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wp_m = 0;
        cnt_m = 0;
    endtask

    task automatic check_stats(input string tag);
        int a, mx, mn;
        ref_stats(a, mx, mn);
        chk({tag, "_avg"}, avg_temp, a);
        chk({tag, "_max"}, max_temp, mx);
        chk({tag, "_min"}, min_temp, mn);
        chk({tag, "_count"}, entry_count, cnt_m);
    endtask

    task automatic do_sample(input int v);
        int k, ea;
        wait_ready();
        ea = wp_m;
        sample_in = DW'(v);
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        chk("write_we", bram_we, 1);
        chk("write_addr", bram_addr, ea);
        chk("write_din", bram_din, v);
        model_write(v);
        k = 1;
        while (!stats_valid && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("stats_latency", k, 15 + cnt_m);
        check_stats("stats");
        chk("ready_low_done", sample_ready, 0);
        @(negedge clk);
        chk("stats_pulse_len", stats_valid, 0);
        chk("ready_after_done", sample_ready, 1);
    endtask

    task automatic do_read(input int a);
        int k;
        wait_ready();
        rd_addr = AW'(a);
        rd_req = 1'b1;
        @(negedge clk);
        k = 1;
        while (!rd_ack && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("rd_latency", k, 2);
        chk("rd_data", rd_data, mem_m[a]);
        rd_req = 1'b0;
        @(negedge clk);
        chk("rd_ack_pulse", rd_ack, 0);
        chk("rd_data_hold", rd_data, mem_m[a]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        int seen, k, n, a, mx, mn;

        // Reset and idle
        do_reset();
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (stats_valid || rd_ack || bram_we) seen++;
        end
        chk("idle_pulses", seen, 0);
        chk("rst_avg", avg_temp, 0);
        chk("rst_max", max_temp, 0);
        chk("rst_min", min_temp, 255);
        chk("rst_count", entry_count, 0);
        chk("rst_ready", sample_ready, 1);
        chk("rst_rd_data", rd_data, 0);

        // Single sample
        do_sample(25);
        chk("single_avg", avg_temp, 25);

        // Three samples
        do_reset();
        do_sample(10);
        do_sample(20);
        do_sample(31);
        chk("three_avg", avg_temp, 20);
        chk("three_max", max_temp, 31);
        chk("three_min", min_temp, 10);

        // Reset during SCAN of the third sample
        do_reset();
        do_sample(40);
        do_sample(50);
        wait_ready();
        sample_in = 8'd60;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wp_m = 0;
        cnt_m = 0;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (stats_valid || rd_ack || bram_we) seen++;
        end
        chk("abort_pulses", seen, 0);
        chk("abort_count", entry_count, 0);
        chk("abort_avg", avg_temp, 0);
        chk("abort_max", max_temp, 0);
        chk("abort_min", min_temp, 255);
        chk("abort_ready", sample_ready, 1);

        // Wrap-around
        do_reset();
        for (int i = 1; i <= 12; i++) do_sample(i);
        chk("wrap_avg", avg_temp, 7);
        chk("wrap_max", max_temp, 12);
        chk("wrap_min", min_temp, 3);
        chk("wrap_count", entry_count, 10);
        chk("wrap_wp", wp_m, 2);
        do_read(0);
        chk("wrap_addr0", rd_data, 11);
        do_read(1);
        chk("wrap_addr1", rd_data, 12);
        do_read(2);
        chk("wrap_addr2", rd_data, 3);

        // Arbitration: sample beats a simultaneous read
        wait_ready();
        rd_addr = '0;
        rd_req = 1'b1;
        sample_in = 8'd200;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        chk("arb_sample_wins", bram_we, 1);
        chk("arb_write_addr", bram_addr, 2);
        model_write(200);
        n = cnt_m;
        k = 1;
        seen = 0;
        while (!rd_ack && k < 60) begin
            if (stats_valid) begin
                seen = k;
                ref_stats(a, mx, mn);
                chk("arb_avg", avg_temp, a);
                chk("arb_max", max_temp, mx);
            end
            @(negedge clk);
            k++;
        end
        chk("arb_stats_cycle", seen, 15 + n);
        chk("arb_rd_latency", k, 18 + n);
        chk("arb_rd_data", rd_data, mem_m[0]);
        rd_req = 1'b0;
        @(negedge clk);

        // Randomized mix against the reference model
        do_reset();
        for (int i = 0; i < 30; i++) begin
            if (cnt_m > 0 && $urandom_range(0, 2) == 0)
                do_read(int'($urandom_range(0, cnt_m - 1)));
            else
                do_sample(int'($urandom_range(0, 255)));
        end
        do_sample(255);
        do_sample(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/temp_buffer_sequencer.md
# temp_buffer_sequencer

Sequencer for the single-port temperature-history BRAM. It owns the only BRAM port and shares it between two requesters. Incoming samples get ring-buffer writes plus a full-buffer statistics scan. Host readback requests get single-entry reads. Every accepted sample produces one refreshed set of avg/max/min statistics with a fixed, count-dependent latency. A sequential restoring divider computes the average.

## Interface

Parameters:
- DEPTH, 10, ring-buffer entries used (addresses 0..DEPTH-1)
- AW, 4, BRAM address width
- DW, 8, sample width, unsigned
- SW, 12, sum accumulator width (DEPTH*255 = 2550 fits)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- sample_in  in  DW  new temperature sample
- sample_valid  in  1  sample present; held until accepted
- sample_ready  out  1  high only in IDLE; accept = sample_valid & sample_ready
- rd_req  in  1  host readback request; held until rd_ack
- rd_addr  in  AW  readback address, sampled on grant
- rd_ack  out  1  one-cycle pulse, rd_data valid that cycle
- rd_data  out  DW  readback data, held until next rd_ack
- bram_we  out  1  BRAM write enable
- bram_addr  out  AW  BRAM address
- bram_din  out  DW  BRAM write data
- bram_dout  in  DW  BRAM read data, valid one cycle after address (no output register)
- avg_temp  out  DW  floor(sum/count) over valid entries
- max_temp  out  DW  maximum over valid entries
- min_temp  out  DW  minimum over valid entries
- stats_valid  out  1  one-cycle pulse when avg/max/min update
- entry_count  out  AW  valid entries, 0..DEPTH, saturating

## Operation

- States: IDLE, WRITE, SCAN, DRAIN, DIV, DONE, RD_ADDR, RD_DATA.
- IDLE arbitration:
  - If sample_valid is high, accept the sample and go to WRITE. Samples have priority over rd_req in the same cycle.
  - Otherwise, if rd_req is high, latch rd_addr and go to RD_ADDR.
- WRITE (1 cycle):
  - bram_we=1, bram_addr=wp, bram_din=latched sample.
  - wp advances, wrapping DEPTH-1 to 0.
  - entry_count increments and saturates at DEPTH.
  - Clear the accumulators: sum=0, max=0, min=255.
- SCAN (N cycles, N = entry_count after the write):
  - Issue bram_addr 0..N-1, one per cycle, with bram_we=0.
  - Capture data from the previous cycle's address into sum/max/min, from the 2nd SCAN cycle onward.
- DRAIN (1 cycle): capture the last read, then go to DIV.
- DIV (12 cycles): restoring divide of the SW-bit sum by N, one quotient bit per cycle. The quotient fits DW, since sum ≤ 255*N.
- DONE (1 cycle):
  - Register avg/max/min onto the outputs.
  - stats_valid=1.
  - Return to IDLE.
- RD_ADDR: bram_addr=latched rd_addr, bram_we=0.
- RD_DATA: rd_data=bram_dout, rd_ack=1, then return to IDLE.
- rd_addr ≥ DEPTH or an unwritten entry: return whatever the BRAM holds; no error flag.
- Outside WRITE, bram_we=0. bram_addr/bram_din hold their last value when unused.
- Arithmetic is unsigned. Compares use strict >/<, so ties keep the existing value.

## Timing

- Reset values (the cycle after rst is sampled high):
  - state=IDLE, wp=0, entry_count=0
  - avg_temp=0, max_temp=0, min_temp=255
  - stats_valid=0, rd_ack=0, rd_data=0, bram_we=0, bram_addr=0, bram_din=0
  - sample_ready=1 from the first post-reset cycle
- Reset mid-operation: abort in any state. No further BRAM write, no stats_valid, no rd_ack. BRAM contents are untouched but logically discarded, since entry_count=0.
- Sample latency, acceptance in cycle T:
  - WRITE at T+1.
  - SCAN at T+2..T+1+N.
  - DRAIN at T+2+N.
  - DIV at T+3+N..T+14+N.
  - DONE and stats_valid at T+15+N (T+16 for the first sample, T+25 when full).
- sample_ready is low from T+1 through DONE. It is high again the cycle after DONE. Back-to-back samples are accepted every N+16 cycles.
- Readback: grant at cycle T, rd_ack at T+2. A rd_req held during a sample sequence is granted in the first IDLE cycle with no sample_valid.
- Outputs are stable except at DONE. entry_count updates at the end of WRITE.

## Test plan

- Reset checks:
  - Reset, then idle for 5 cycles: avg=0, max=0, min=255, entry_count=0, sample_ready=1, no pulses.
  - Assert rst during SCAN of the 3rd sample: no stats_valid, entry_count=0, outputs back to reset values.
- Single sample: sample 25 accepted at T. Required: bram_we at T+1 with addr 0, stats_valid at T+16, avg=max=min=25, entry_count=1.
- Three samples: 10, 20, 31 back-to-back. Required: final avg=20 (61/3), max=31, min=10, entry_count=3.
- Wrap-around: samples 1..12. Required: the buffer holds 11,12,3..10 and wp=2. Final stats: sum 75, avg=7, max=12, min=3, entry_count=10. Last latency is 25 cycles.
- Arbitration: rd_req(addr 0) and sample_valid asserted in the same IDLE cycle. The sample wins. rd_ack arrives 2 cycles after the post-DONE IDLE grant, with rd_data equal to the entry at addr 0.
